// File: rtl/pipe_stage_register.sv
// Generic pipeline stage register: valid/ready handshake with 2-entry skid buffer and sync flush.
// Define PIPE_STAGE_PERF_EN to add the StallCnt/BubbleCnt saturating performance counters.
module pipe_stage_register #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16
`ifdef PIPE_STAGE_PERF_EN
  ,parameter int CNT_W = 16
`endif
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Flush,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [CTRL_W-1:0] In_ctrl,
  input  logic [DATA_W-1:0] In_data,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [CTRL_W-1:0] Out_ctrl,
  output logic [DATA_W-1:0] Out_data
`ifdef PIPE_STAGE_PERF_EN
  ,output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0]  BubbleCnt
`endif
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              acc, rel;

  assign acc = In_valid & in_ready_q;
  assign rel = out_valid_q & Out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          main_ctrl_d = In_ctrl;
          main_data_d = In_data;
          state_d     = ST_FULL;
        end
      end
      ST_FULL: begin
        if (acc && rel) begin
          main_ctrl_d = In_ctrl;
          main_data_d = In_data;
        end else if (acc) begin
          skid_ctrl_d = In_ctrl;
          skid_data_d = In_data;
          state_d     = ST_SKID;
        end else if (rel) begin
          // Control is zeroed so an idle stage can never assert a write enable downstream
          main_ctrl_d = '0;
          state_d     = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (rel) begin
          main_ctrl_d = skid_ctrl_q;
          main_data_d = skid_data_q;
          skid_ctrl_d = '0;
          state_d     = ST_FULL;
        end
      end
      default: begin
        main_ctrl_d = '0;
        skid_ctrl_d = '0;
        state_d     = ST_EMPTY;
      end
    endcase
    // Flush kills both entries; any same-cycle accept or release is discarded
    if (Flush) begin
      main_ctrl_d = '0;
      main_data_d = main_data_q;
      skid_ctrl_d = '0;
      skid_data_d = skid_data_q;
      state_d     = ST_EMPTY;
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_SKID);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= ST_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end

  assign In_ready  = in_ready_q;
  assign Out_valid = out_valid_q;
  assign Out_ctrl  = main_ctrl_q;
  assign Out_data  = main_data_q;

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (out_valid_q && !Out_ready && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (!out_valid_q && !(&bubble_cnt_q))             bubble_cnt_d = bubble_cnt_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign StallCnt  = stall_cnt_q;
  assign BubbleCnt = bubble_cnt_q;
`else
  // Counters absent in this build; handshake path above is unchanged.
`endif

endmodule

// File: tb/tb_pipe_stage_register.sv
// Directed self-checking bench for pipe_stage_register (perf counters checked when PIPE_STAGE_PERF_EN is set).
module tb_pipe_stage_register;
  localparam int DW = 8;
  localparam int CW = 4;

  logic          Clk = 1'b0;
  logic          Rst_n, Flush, In_valid, Out_ready;
  logic          In_ready, Out_valid;
  logic [CW-1:0] In_ctrl, Out_ctrl;
  logic [DW-1:0] In_data, Out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [3:0]    StallCnt, BubbleCnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  pipe_stage_register #(
    .DATA_W(DW),
    .CTRL_W(CW)
`ifdef PIPE_STAGE_PERF_EN
    ,.CNT_W(4)
`endif
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
    .In_valid(In_valid), .In_ready(In_ready), .In_ctrl(In_ctrl), .In_data(In_data),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Out_ctrl(Out_ctrl), .Out_data(Out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,.StallCnt(StallCnt), .BubbleCnt(BubbleCnt)
`endif
  );

  // control tag derived from data, always non-zero so clearing is observable
  function automatic logic [CW-1:0] cf(input logic [DW-1:0] d);
    return d[CW-1:0] | 4'h8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [DW-1:0] d);
    In_valid = 1'b1;
    In_data  = d;
    In_ctrl  = cf(d);
  endtask

  task automatic idle;
    In_valid = 1'b0;
    In_data  = '0;
    In_ctrl  = '0;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d, input logic rdy);
    chk({tag, "_valid"}, 32'(Out_valid), 32'(v));
    chk({tag, "_ctrl"}, 32'(Out_ctrl), v ? 32'(cf(d)) : 32'h0);
    if (v) chk({tag, "_data"}, 32'(Out_data), 32'(d));
    chk({tag, "_inrdy"}, 32'(In_ready), 32'(rdy));
  endtask

  initial begin
    Rst_n = 1'b0; Flush = 1'b0; Out_ready = 1'b0; idle();
    repeat (2) tick();
    chk("rst_valid", 32'(Out_valid), 0);
    chk("rst_ctrl", 32'(Out_ctrl), 0);
    chk("rst_data", 32'(Out_data), 0);
    chk("rst_inrdy", 32'(In_ready), 1);
    Rst_n = 1'b1;

    // back-to-back stream, downstream always ready
    Out_ready = 1'b1;
    push(8'h11); tick(); chk_out("s11", 1, 8'h11, 1);
    push(8'h12); tick(); chk_out("s12", 1, 8'h12, 1);
    push(8'h13); tick(); chk_out("s13", 1, 8'h13, 1);
    push(8'h14); tick(); chk_out("s14", 1, 8'h14, 1);
    idle(); tick(); chk_out("drain", 0, 8'h00, 1);
    chk("hold_data", 32'(Out_data), 32'h14);

    // stall fills skid, then release in order
    Out_ready = 1'b0;
    push(8'h0A); tick(); chk_out("stA", 1, 8'h0A, 1);
    push(8'h0B); tick(); chk_out("stB", 1, 8'h0A, 0);
    push(8'h0C); tick(); chk_out("stC_wait", 1, 8'h0A, 0);
    Out_ready = 1'b1;
    tick(); chk_out("relB", 1, 8'h0B, 1);
    tick(); chk_out("relC", 1, 8'h0C, 1);
    idle(); tick(); chk_out("relEmpty", 0, 8'h00, 1);

    // FULL with simultaneous accept and release
    push(8'h54); tick(); chk_out("f54", 1, 8'h54, 1);
    push(8'h55); tick(); chk_out("f55", 1, 8'h55, 1);
    idle(); tick(); chk_out("fEmpty", 0, 8'h00, 1);

    // flush from SKID with a concurrent offer of 0x0F
    Out_ready = 1'b0;
    push(8'h21); tick();
    push(8'h22); tick(); chk_out("preflush", 1, 8'h21, 0);
    Flush = 1'b1; push(8'h0F); tick();
    chk_out("flush", 0, 8'h00, 1);
    Flush = 1'b0; idle(); Out_ready = 1'b1; tick();
    chk_out("postflush", 0, 8'h00, 1);
    chk("postflush_data", 32'(Out_data), 32'h21);

    // async reset while SKID holds two entries
    Out_ready = 1'b0;
    push(8'h31); tick();
    push(8'h32); tick(); chk("pre_rst_inrdy", 32'(In_ready), 0);
    idle();
    #2 Rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(Out_valid), 0);
    chk("midrst_ctrl", 32'(Out_ctrl), 0);
    chk("midrst_inrdy", 32'(In_ready), 1);
    chk("midrst_data", 32'(Out_data), 0);
    tick();
    Out_ready = 1'b1;
    push(8'h41); Rst_n = 1'b1; tick(); chk_out("after_rst", 1, 8'h41, 1);
    idle(); tick();

`ifdef PIPE_STAGE_PERF_EN
    Rst_n = 1'b0; Out_ready = 1'b0; tick();
    chk("cnt_rst_stall", 32'(StallCnt), 0);
    chk("cnt_rst_bubble", 32'(BubbleCnt), 0);
    push(8'h66); Rst_n = 1'b1; tick(); idle();
    chk("cnt_bubble1", 32'(BubbleCnt), 1);
    repeat (5) tick();
    chk("cnt_stall5", 32'(StallCnt), 5);
    repeat (15) tick();
    chk("cnt_stall_sat", 32'(StallCnt), 15);
    chk("cnt_bubble_hold", 32'(BubbleCnt), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
